// File: rtl/skinny_pkg.sv
// Shared definitions for the SKINNY-128-384+ block controller: FSM states,
// round count, beat count, control-bit layout and the round-constant step.
package skinny_pkg;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_LOAD = 3'd1,
        ST_RUN  = 3'd2,
        ST_OUT  = 3'd3,
        ST_CNT  = 3'd4
    } state_e;

    // SKINNY-128-384+ round count; the datapath does two rounds per cycle.
    localparam int NR_DEFAULT = 40;

    // pdi/sdi and pdo words per block.
    localparam int BEATS = 4;

    // Bit positions inside every {rst,enc,se} control triple.
    localparam int CTL_RST = 2;
    localparam int CTL_ENC = 1;
    localparam int CTL_SE  = 0;

    localparam logic [2:0] CTL_HOLD  = 3'b000;
    localparam logic [2:0] CTL_RESET = 3'(1 << CTL_RST);
    localparam logic [2:0] CTL_ROUND = 3'(1 << CTL_ENC);
    localparam logic [2:0] CTL_SHIFT = 3'((1 << CTL_ENC) | (1 << CTL_SE));

    // One step of the 6-bit round-constant LFSR.
    function automatic logic [5:0] rc_step(input logic [5:0] rc);
        return {rc[4:0], rc[5] ^ rc[4] ^ 1'b1};
    endfunction

endpackage

// File: rtl/skinny_ctrl_if.sv
// Block-level handshake between the host and the SKINNY controller.
interface skinny_ctrl_if;

    logic       start;
    logic [7:0] dom_in;
    logic       dec_in;
    logic       ad_in;
    logic       din_valid;
    logic       din_ready;
    logic       dout_valid;
    logic       dout_ready;
    logic       done;

    // Host side: issues blocks, feeds words, drains output words.
    modport master (
        output start, dom_in, dec_in, ad_in, din_valid, dout_ready,
        input  din_ready, dout_valid, done
    );

    // Controller side.
    modport slave (
        input  start, dom_in, dec_in, ad_in, din_valid, dout_ready,
        output din_ready, dout_valid, done
    );

endinterface

// File: rtl/skinny_rc2.sv
// Two chained steps of the round-constant LFSR, so one cycle covers the
// constants of rounds 2k and 2k+1.
module skinny_rc2
    import skinny_pkg::*;
(
    input  logic [5:0] rc_in,
    output logic [5:0] rc_1,
    output logic [5:0] rc_2
);

    // rc_1 feeds the even round, rc_2 the odd round and the next register value
    always_comb begin
        rc_1 = rc_step(rc_in);
        rc_2 = rc_step(rc_1);
    end

endmodule

// File: rtl/skinny_ctrl.sv
// SKINNY-128-384+ block controller: sequences load, round, output and
// counter-update phases and drives the register control strobes.
module skinny_ctrl
    import skinny_pkg::*;
#(
    parameter int NR = NR_DEFAULT
) (
    input  logic         clk,
    input  logic         rst,
    skinny_ctrl_if.slave bus,
    output logic [2:0]   s_ctl,
    output logic [2:0]   x_ctl,
    output logic [2:0]   y_ctl,
    output logic [2:0]   z_ctl,
    output logic         erst,
    output logic         correct_cnt,
    output logic         tk1s,
    output logic [5:0]   constant,
    output logic [5:0]   constant2,
    output logic [7:0]   domain,
    output logic [3:0]   decrypt
);

    localparam int RUN_CYCLES = NR / 2;
    localparam int RUN_W      = (RUN_CYCLES > 1) ? $clog2(RUN_CYCLES) : 1;
    localparam logic [RUN_W-1:0] RUN_LAST  = RUN_W'(RUN_CYCLES - 1);
    localparam logic [1:0]       BEAT_LAST = 2'(BEATS - 1);

    state_e           state_q, state_d;
    logic [1:0]       beat_q, beat_d;
    logic [RUN_W-1:0] run_q, run_d;
    logic [5:0]       rc_q, rc_d;
    logic [5:0]       rc_nx1, rc_nx2;
    logic [7:0]       dom_q, dom_d;
    logic             dec_q, dec_d;
    logic             ad_q, ad_d;

    skinny_rc2 u_rc2 (
        .rc_in (rc_q),
        .rc_1  (rc_nx1),
        .rc_2  (rc_nx2)
    );

    // State register plus counters, LFSR and latched block fields
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            beat_q  <= '0;
            run_q   <= '0;
            rc_q    <= '0;
            dom_q   <= '0;
            dec_q   <= 1'b0;
            ad_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            beat_q  <= beat_d;
            run_q   <= run_d;
            rc_q    <= rc_d;
            dom_q   <= dom_d;
            dec_q   <= dec_d;
            ad_q    <= ad_d;
        end
    end

    // Next-state logic with counter, LFSR and field-latch updates
    always_comb begin
        state_d = state_q;
        beat_d  = beat_q;
        run_d   = run_q;
        rc_d    = rc_q;
        dom_d   = dom_q;
        dec_d   = dec_q;
        ad_d    = ad_q;
        case (state_q)
            ST_IDLE: begin
                if (bus.start) begin
                    state_d = ST_LOAD;
                    beat_d  = '0;
                    rc_d    = '0;
                    dom_d   = bus.dom_in;
                    dec_d   = bus.dec_in;
                    ad_d    = bus.ad_in;
                end
            end
            ST_LOAD: begin
                if (bus.din_valid) begin
                    beat_d = beat_q + 2'd1;
                    if (beat_q == BEAT_LAST) begin
                        state_d = ST_RUN;
                        run_d   = '0;
                    end
                end
            end
            ST_RUN: begin
                rc_d = rc_nx2;
                if (run_q == RUN_LAST) begin
                    state_d = ST_OUT;
                    beat_d  = '0;
                end else begin
                    run_d = run_q + 1'b1;
                end
            end
            ST_OUT: begin
                if (bus.dout_ready) begin
                    beat_d = beat_q + 2'd1;
                    if (beat_q == BEAT_LAST) begin
                        state_d = ST_CNT;
                    end
                end
            end
            ST_CNT: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Moore/Mealy output decode; handshakes only qualify the strobes
    always_comb begin
        s_ctl          = CTL_HOLD;
        x_ctl          = CTL_HOLD;
        y_ctl          = CTL_HOLD;
        z_ctl          = CTL_HOLD;
        erst           = 1'b0;
        correct_cnt    = 1'b0;
        constant       = '0;
        constant2      = '0;
        decrypt        = 4'h0;
        bus.din_ready  = 1'b0;
        bus.dout_valid = 1'b0;
        bus.done       = 1'b0;
        tk1s           = ad_q;
        domain         = dom_q;
        case (state_q)
            ST_IDLE: begin
                s_ctl = CTL_RESET;
                x_ctl = CTL_RESET;
                y_ctl = CTL_RESET;
                z_ctl = CTL_RESET;
                erst  = bus.start;
            end
            ST_LOAD: begin
                bus.din_ready = 1'b1;
                if (bus.din_valid) begin
                    s_ctl = CTL_SHIFT;
                    x_ctl = CTL_SHIFT;
                    y_ctl = CTL_SHIFT;
                end
            end
            ST_RUN: begin
                s_ctl     = CTL_ROUND;
                x_ctl     = CTL_ROUND;
                y_ctl     = CTL_ROUND;
                z_ctl     = CTL_ROUND;
                constant  = rc_nx1;
                constant2 = rc_nx2;
            end
            ST_OUT: begin
                bus.dout_valid = 1'b1;
                decrypt        = dec_q ? 4'hF : 4'h0;
                if (bus.dout_ready) begin
                    s_ctl = CTL_SHIFT;
                end
            end
            ST_CNT: begin
                z_ctl       = CTL_SHIFT;
                correct_cnt = 1'b1;
                bus.done    = 1'b1;
            end
            default: begin
                s_ctl = CTL_RESET;
            end
        endcase
    end

endmodule
